// File: rtl/ttl_sync_pkg.sv
// Shared constants and helpers for the ttl_sync video blocks.
package ttl_sync_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned PHASE_W    = 3;
  localparam logic [2:0]  PHASE_LOAD = 3'd7;

  // Bit-reverse a byte (horizontal flip of an 8-pixel tile row).
  function automatic logic [BYTE_W-1:0] bitrev8(input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] r;
    for (int i = 0; i < BYTE_W; i++) begin
      r[i] = b[BYTE_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ttl_cen_edge_sync.sv
// Turns a clock-enable level into a one-clk tick on its rising edge, sampled on clk.
module ttl_cen_edge_sync (
  input  logic clk,
  input  logic RSTn,
  input  logic cen,
  output logic tick
);

  logic last_cen_q;

  // Remember cen from the previous clk; reset to 1 so a cen already high gives no tick.
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      last_cen_q <= 1'b1;
    end else begin
      last_cen_q <= cen;
    end
  end

  assign tick = cen & ~last_cen_q;

endmodule

// File: rtl/gfx_plane_serializer_sync.sv
// Bitplane pixel serializer: parallel-loads PLANES bytes every 8 pixel ticks and shifts
// one bit per tick, MSB first, producing one PLANES-wide pixel.
module gfx_plane_serializer_sync
  import ttl_sync_pkg::*;
#(
  parameter int unsigned PLANES   = 4,
  parameter int unsigned AUTOLOAD = 1
) (
  input  logic                     clk,
  input  logic                     RSTn,
  input  logic                     cen,
  input  logic                     INH,
  input  logic                     LOADn,
  input  logic                     FLIP,
  input  logic [BYTE_W*PLANES-1:0] D,
  output logic [PLANES-1:0]        PIX,
  output logic [PHASE_W-1:0]       PHASE,
  output logic                     LDSTB
);

  logic tick;
  logic load;
  logic shift;

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               ldstb_q;

  ttl_cen_edge_sync u_cen_edge (
    .clk  (clk),
    .RSTn (RSTn),
    .cen  (cen),
    .tick (tick)
  );

  // Load/shift decode; INH overrides both.
  always_comb begin
    load = 1'b0;
    if (tick && !INH) begin
      if (AUTOLOAD != 0) begin
        load = (phase_q == PHASE_LOAD);
      end else begin
        load = ~LOADn;
      end
    end
    shift = tick & ~INH & ~load;
  end

  // Next pixel phase: cleared on load, wraps on shift.
  always_comb begin
    phase_d = phase_q;
    if (load) begin
      phase_d = '0;
    end else if (shift) begin
      phase_d = phase_q + 3'd1;
    end
  end

  // Phase counter and load strobe for the upstream latches.
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      phase_q <= '0;
      ldstb_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      ldstb_q <= load;
    end
  end

  for (genvar p = 0; p < PLANES; p++) begin : g_plane
    logic [BYTE_W-1:0] sr_q, sr_d;
    logic [BYTE_W-1:0] byte_in;

    assign byte_in = D[BYTE_W*p +: BYTE_W];

    // Next shift register value: load (optionally flipped) or shift left with zero fill.
    always_comb begin
      sr_d = sr_q;
      if (load) begin
        sr_d = FLIP ? bitrev8(byte_in) : byte_in;
      end else if (shift) begin
        sr_d = {sr_q[BYTE_W-2:0], 1'b0};
      end
    end

    // Plane shift register state.
    always_ff @(posedge clk) begin
      if (!RSTn) begin
        sr_q <= '0;
      end else begin
        sr_q <= sr_d;
      end
    end

    assign PIX[p] = sr_q[BYTE_W-1];
  end

  assign PHASE = phase_q;
  assign LDSTB = ldstb_q;

endmodule
